trap_controller: RTL and testbench
==================================

Name: trap_controller

Overview:
- Machine-mode trap sequencer for the rv32ima core.
- Samples the exception flags and current PC from the pipeline, picks the highest-priority cause, and records mepc/mcause.
- Handshakes a pipeline flush, then issues a single-cycle redirect to the mtvec base.
- Also sequences mret returns. Owns mtvec, mepc and mcause, and drives epc_value, trap_handler_addr and trap_enable to the fetch stage.

Parameters:
- RESET_MTVEC, 32'h0000_0100, mtvec value after reset (bits [1:0] forced 0).
- XLEN, 32, data width; fixed at 32 for rv32ima.

Ports:
- CLK  input  1  clock.
- nRST  input  1  asynchronous active-low reset.
- inst_addr_misalign_flag  input  1  instruction address misaligned.
- load_addr_misalign_flag  input  1  load address misaligned.
- store_amo_addr_misalign_flag  input  1  store/AMO address misaligned.
- inst_illegal_flag  input  1  illegal instruction.
- ebreak_flag  input  1  EBREAK executed.
- ecall_flag  input  1  ECALL executed (M-mode).
- current_pc  input  32  PC of the instruction raising flags.
- mret_flag  input  1  MRET executed.
- flush_ack  input  1  pipeline drained, no younger instruction will commit.
- mtvec_we  input  1  software write to mtvec.
- mtvec_wdata  input  32  mtvec write data.
- flush_req  output  1  request pipeline flush.
- trap_enable  output  1  one-cycle redirect strobe to trap_handler_addr.
- mret_enable  output  1  one-cycle redirect strobe to epc_value.
- trap_handler_addr  output  32  mtvec with bits [1:0] cleared.
- epc_value  output  32  current mepc.
- mcause  output  32  latched cause code.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset, asynchronous on nRST low:
  - State IDLE; all strobes 0; busy 0.
  - mepc 0, mcause 0, mtvec RESET_MTVEC.
  - A reset mid-sequence aborts it; no redirect is issued.
- Cause priority, highest first, with cause codes:
  - inst_addr_misalign 0
  - inst_illegal 2
  - ecall 11
  - ebreak 3
  - load_misalign 4
  - store_amo_misalign 6
- Trap sequence:
  - IDLE: any flag set → latch mepc = {current_pc[31:2], 2'b00}, latch mcause, go FLUSH.
  - A trap and mret_flag in the same cycle → the trap wins and mret is dropped.
  - FLUSH: flush_req = 1, held until flush_ack.
  - flush_ack seen → go REDIRECT next cycle. flush_ack in the same cycle flush_req first rises is accepted, giving a minimum latency of 2 cycles from flag to trap_enable.
  - REDIRECT: trap_enable = 1 for exactly one cycle; trap_handler_addr valid that cycle; then IDLE.
  - Flags arriving in FLUSH or REDIRECT are ignored. They belong to flushed instructions; mepc and mcause are not overwritten.
- mret sequence:
  - IDLE with mret_flag and no trap flag → go MRET_FLUSH (flush_req = 1 until flush_ack).
  - Then MRET: mret_enable = 1 for one cycle; epc_value = mepc; then IDLE.
- Status outputs:
  - busy = 1 in every non-IDLE state.
  - trap_enable and mret_enable are never high together.
- mtvec:
  - mtvec_we updates mtvec on the next edge in any state, with bits [1:0] written as 0 (direct mode only).
  - A write in the same cycle as REDIRECT does not affect that cycle's trap_handler_addr; the old value is used.
- Outputs are registered. trap_handler_addr, epc_value and mcause are continuously driven from the registers.

Optional Feature:
- TRAP_CTRL_MTVAL_EN:
  - Defined: adds input fault_addr[31:0] and output mtval[31:0] (reset 0). On trap entry mtval latches:
    - fault_addr for causes 0, 4 and 6;
    - current_pc for cause 3;
    - 0 for causes 2 and 11.
  - Undefined: neither port exists and no mtval register is built.

Test Plan:
- Single ecall:
  - Stimulus: ecall_flag=1, current_pc=0x0000_2004, mtvec reset 0x100; flush_ack asserted 3 cycles after flush_req rises.
  - Required: mcause=11, epc_value=0x2004, one-cycle trap_enable with trap_handler_addr=0x100, then busy=0.
- Priority:
  - Stimulus: illegal, ebreak and load_misalign set in the same cycle.
  - Required: mcause=2; flags re-asserted during FLUSH leave mcause=2 and mepc unchanged.
- mret:
  - Stimulus: after a trap with mepc=0x2004, mret_flag=1 then flush_ack.
  - Required: mret_enable pulses once with epc_value=0x2004; trap_enable stays 0.
- Trap versus mret collision:
  - Stimulus: ecall_flag and mret_flag in the same cycle.
  - Required: trap sequence runs, mret_enable never asserts.
- mtvec write and reset:
  - Stimulus: mtvec_we with 0x8000_0003.
  - Required: trap_handler_addr=0x8000_0000.
  - Stimulus: assert nRST low during FLUSH.
  - Required: flush_req, busy and strobes go 0 immediately; mtvec returns to 0x100.
- TRAP_CTRL_MTVAL_EN:
  - Stimulus: store_amo_addr_misalign with fault_addr=0x1003.
  - Required: mcause=6, mtval=0x1003.
  - Stimulus: ebreak at current_pc=0x40.
  - Required: mtval=0x40.

Source files
------------

// File: rtl/trap_controller.sv
// trap_controller: machine-mode trap/mret sequencer for the rv32ima core.
// Picks the highest-priority exception, records mepc/mcause, handshakes a
// pipeline flush and then issues a one-cycle redirect to mtvec (trap) or to
// mepc (mret). Owns the mtvec, mepc and mcause registers.
// Optional build macro TRAP_CTRL_MTVAL_EN adds fault_addr input and mtval output.
module trap_controller #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0100
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            inst_addr_misalign_flag,
    input  logic            load_addr_misalign_flag,
    input  logic            store_amo_addr_misalign_flag,
    input  logic            inst_illegal_flag,
    input  logic            ebreak_flag,
    input  logic            ecall_flag,
    input  logic [XLEN-1:0] current_pc,
    input  logic            mret_flag,
    input  logic            flush_ack,
    input  logic            mtvec_we,
    input  logic [XLEN-1:0] mtvec_wdata,
`ifdef TRAP_CTRL_MTVAL_EN
    input  logic [XLEN-1:0] fault_addr,
    output logic [XLEN-1:0] mtval,
`endif
    output logic            flush_req,
    output logic            trap_enable,
    output logic            mret_enable,
    output logic [XLEN-1:0] trap_handler_addr,
    output logic [XLEN-1:0] epc_value,
    output logic [XLEN-1:0] mcause,
    output logic            busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_REDIRECT,
        S_MRET_FLUSH,
        S_MRET
    } state_t;

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    state_t          state_q, state_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic            flush_req_q, flush_req_d;
    logic            trap_enable_q, trap_enable_d;
    logic            mret_enable_q, mret_enable_d;
    logic            busy_q, busy_d;

    logic            trap_any;
    logic [XLEN-1:0] cause_sel;

`ifdef TRAP_CTRL_MTVAL_EN
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic [XLEN-1:0] mtval_sel;
`endif

    // Fixed-priority cause selection (and the matching trap value when built)
    always_comb begin
        trap_any  = inst_addr_misalign_flag | inst_illegal_flag | ecall_flag |
                    ebreak_flag | load_addr_misalign_flag | store_amo_addr_misalign_flag;
        cause_sel = '0;
`ifdef TRAP_CTRL_MTVAL_EN
        mtval_sel = '0;
`endif
        if (inst_addr_misalign_flag) begin
            cause_sel = XLEN'(0);
`ifdef TRAP_CTRL_MTVAL_EN
            mtval_sel = fault_addr;
`endif
        end else if (inst_illegal_flag) begin
            cause_sel = XLEN'(2);
        end else if (ecall_flag) begin
            cause_sel = XLEN'(11);
        end else if (ebreak_flag) begin
            cause_sel = XLEN'(3);
`ifdef TRAP_CTRL_MTVAL_EN
            mtval_sel = current_pc;
`endif
        end else if (load_addr_misalign_flag) begin
            cause_sel = XLEN'(4);
`ifdef TRAP_CTRL_MTVAL_EN
            mtval_sel = fault_addr;
`endif
        end else if (store_amo_addr_misalign_flag) begin
            cause_sel = XLEN'(6);
`ifdef TRAP_CTRL_MTVAL_EN
            mtval_sel = fault_addr;
`endif
        end
    end

    // Next-state logic; strobes are decoded from the next state so they are registered
    always_comb begin
        state_d  = state_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        mtvec_d  = mtvec_we ? (mtvec_wdata & ALIGN_MASK) : mtvec_q;
`ifdef TRAP_CTRL_MTVAL_EN
        mtval_d  = mtval_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                // A trap in the same cycle as mret wins; the mret is dropped.
                if (trap_any) begin
                    mepc_d   = current_pc & ALIGN_MASK;
                    mcause_d = cause_sel;
`ifdef TRAP_CTRL_MTVAL_EN
                    mtval_d  = mtval_sel;
`endif
                    state_d  = S_FLUSH;
                end else if (mret_flag) begin
                    state_d = S_MRET_FLUSH;
                end
            end
            S_FLUSH:      if (flush_ack) state_d = S_REDIRECT;
            S_REDIRECT:   state_d = S_IDLE;
            S_MRET_FLUSH: if (flush_ack) state_d = S_MRET;
            S_MRET:       state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
        flush_req_d   = (state_d == S_FLUSH) || (state_d == S_MRET_FLUSH);
        trap_enable_d = (state_d == S_REDIRECT);
        mret_enable_d = (state_d == S_MRET);
        busy_d        = (state_d != S_IDLE);
    end

    // State, CSR and output registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= S_IDLE;
            mepc_q        <= '0;
            mcause_q      <= '0;
            mtvec_q       <= RESET_MTVEC & ALIGN_MASK;
            flush_req_q   <= 1'b0;
            trap_enable_q <= 1'b0;
            mret_enable_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef TRAP_CTRL_MTVAL_EN
            mtval_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            mtvec_q       <= mtvec_d;
            flush_req_q   <= flush_req_d;
            trap_enable_q <= trap_enable_d;
            mret_enable_q <= mret_enable_d;
            busy_q        <= busy_d;
`ifdef TRAP_CTRL_MTVAL_EN
            mtval_q       <= mtval_d;
`endif
        end
    end

    assign flush_req         = flush_req_q;
    assign trap_enable       = trap_enable_q;
    assign mret_enable       = mret_enable_q;
    assign busy              = busy_q;
    assign trap_handler_addr = mtvec_q;
    assign epc_value         = mepc_q;
    assign mcause            = mcause_q;
`ifdef TRAP_CTRL_MTVAL_EN
    assign mtval             = mtval_q;
`endif

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: redirects are predicted into a
// scoreboard queue when stimulus is driven and compared when a strobe appears.
module tb_trap_controller;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        inst_addr_misalign_flag, load_addr_misalign_flag, store_amo_addr_misalign_flag;
    logic        inst_illegal_flag, ebreak_flag, ecall_flag;
    logic [31:0] current_pc;
    logic        mret_flag, flush_ack, mtvec_we;
    logic [31:0] mtvec_wdata;
`ifdef TRAP_CTRL_MTVAL_EN
    logic [31:0] fault_addr;
    logic [31:0] mtval;
`endif
    logic        flush_req, trap_enable, mret_enable, busy;
    logic [31:0] trap_handler_addr, epc_value, mcause;

    typedef struct {
        bit          is_mret;
        logic [31:0] addr;
        logic [31:0] cause;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_mtvec = 32'h0000_0100;
    logic [31:0] exp_mepc  = 32'h0;

    trap_controller #(.XLEN(32), .RESET_MTVEC(32'h0000_0100)) dut (
        .CLK                          (CLK),
        .nRST                         (nRST),
        .inst_addr_misalign_flag      (inst_addr_misalign_flag),
        .load_addr_misalign_flag      (load_addr_misalign_flag),
        .store_amo_addr_misalign_flag (store_amo_addr_misalign_flag),
        .inst_illegal_flag            (inst_illegal_flag),
        .ebreak_flag                  (ebreak_flag),
        .ecall_flag                   (ecall_flag),
        .current_pc                   (current_pc),
        .mret_flag                    (mret_flag),
        .flush_ack                    (flush_ack),
        .mtvec_we                     (mtvec_we),
        .mtvec_wdata                  (mtvec_wdata),
`ifdef TRAP_CTRL_MTVAL_EN
        .fault_addr                   (fault_addr),
        .mtval                        (mtval),
`endif
        .flush_req                    (flush_req),
        .trap_enable                  (trap_enable),
        .mret_enable                  (mret_enable),
        .trap_handler_addr            (trap_handler_addr),
        .epc_value                    (epc_value),
        .mcause                       (mcause),
        .busy                         (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // flags = {inst_addr, illegal, ecall, ebreak, load, store}
    task automatic drive_flags(input logic [5:0] f);
        inst_addr_misalign_flag      = f[5];
        inst_illegal_flag            = f[4];
        ecall_flag                   = f[3];
        ebreak_flag                  = f[2];
        load_addr_misalign_flag      = f[1];
        store_amo_addr_misalign_flag = f[0];
    endtask

    // Scoreboard consumer: every redirect strobe must match the oldest prediction
    always @(negedge CLK) begin
        exp_t e;
        if (trap_enable || mret_enable) begin
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("strobe_exclusive", 32'(trap_enable & mret_enable), 32'd0);
                check("redirect_kind", 32'(mret_enable), 32'(e.is_mret));
                if (e.is_mret) begin
                    check("mret_target", epc_value, e.addr);
                end else begin
                    check("trap_target", trap_handler_addr, e.addr);
                    check("trap_cause", mcause, e.cause);
                end
            end
        end
    end

    task automatic run_trap(input logic [5:0] flags, input logic [31:0] pc,
                            input int unsigned ack_delay, input logic [31:0] exp_cause,
                            input logic [5:0] noise, input bit with_mret,
                            input bit wr_in_redirect);
        drive_flags(flags);
        current_pc = pc;
        mret_flag  = with_mret;
        sb.push_back('{1'b0, exp_mtvec, exp_cause});
        exp_mepc = pc & 32'hFFFF_FFFC;
        @(negedge CLK);
        drive_flags(noise);
        mret_flag  = 1'b0;
        current_pc = 32'h5555_5554;
        check("flush_req_rise", 32'(flush_req), 32'd1);
        check("busy_in_flush", 32'(busy), 32'd1);
        for (int unsigned i = 0; i < ack_delay; i++) begin
            @(negedge CLK);
            check("flush_req_hold", 32'(flush_req), 32'd1);
        end
        flush_ack = 1'b1;
        @(negedge CLK);
        flush_ack = 1'b0;
        drive_flags(6'b0);
        check("trap_enable_latency", 32'(trap_enable), 32'd1);
        check("flush_req_drop", 32'(flush_req), 32'd0);
        if (wr_in_redirect) begin
            mtvec_we    = 1'b1;
            mtvec_wdata = 32'h0000_0207;
            exp_mtvec   = 32'h0000_0204;
        end
        @(negedge CLK);
        mtvec_we = 1'b0;
        check("trap_enable_width", 32'(trap_enable), 32'd0);
        check("busy_back_idle", 32'(busy), 32'd0);
        check("mcause", mcause, exp_cause);
        check("epc_value", epc_value, exp_mepc);
    endtask

    task automatic run_mret();
        mret_flag = 1'b1;
        sb.push_back('{1'b1, exp_mepc, 32'h0});
        @(negedge CLK);
        mret_flag = 1'b0;
        check("mret_flush_req", 32'(flush_req), 32'd1);
        flush_ack = 1'b1;
        @(negedge CLK);
        flush_ack = 1'b0;
        check("mret_enable_on", 32'(mret_enable), 32'd1);
        check("mret_no_trap", 32'(trap_enable), 32'd0);
        @(negedge CLK);
        check("mret_enable_width", 32'(mret_enable), 32'd0);
        check("mret_busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        nRST = 1'b0;
        drive_flags(6'b0);
        current_pc  = '0;
        mret_flag   = 1'b0;
        flush_ack   = 1'b0;
        mtvec_we    = 1'b0;
        mtvec_wdata = '0;
`ifdef TRAP_CTRL_MTVAL_EN
        fault_addr  = '0;
`endif
        repeat (2) @(negedge CLK);
        check("rst_flush_req", 32'(flush_req), 32'd0);
        check("rst_trap_enable", 32'(trap_enable), 32'd0);
        check("rst_mret_enable", 32'(mret_enable), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mcause", mcause, 32'd0);
        check("rst_epc", epc_value, 32'd0);
        check("rst_mtvec", trap_handler_addr, 32'h0000_0100);
`ifdef TRAP_CTRL_MTVAL_EN
        check("rst_mtval", mtval, 32'd0);
`endif
        nRST = 1'b1;
        @(negedge CLK);

        // Single ecall, ack three cycles after flush_req rises
        run_trap(6'b001000, 32'h0000_2004, 3, 32'd11, 6'b0, 1'b0, 1'b0);
        // mret back to the recorded mepc
        run_mret();
        // Priority: illegal beats ebreak and load; flags during FLUSH are ignored
        run_trap(6'b010110, 32'h0000_300B, 2, 32'd2, 6'b101000, 1'b0, 1'b0);
        // ecall and mret together: only the trap runs
        run_trap(6'b001000, 32'h0000_4000, 1, 32'd11, 6'b0, 1'b1, 1'b0);

        // Software mtvec write drops the mode bits
        mtvec_we    = 1'b1;
        mtvec_wdata = 32'h8000_0003;
        @(negedge CLK);
        mtvec_we  = 1'b0;
        exp_mtvec = 32'h8000_0000;
        check("mtvec_write", trap_handler_addr, 32'h8000_0000);

        // Store misalign at minimum latency; mtvec write during REDIRECT must not leak
`ifdef TRAP_CTRL_MTVAL_EN
        fault_addr = 32'h0000_1003;
`endif
        run_trap(6'b000001, 32'h0000_7000, 0, 32'd6, 6'b0, 1'b0, 1'b1);
`ifdef TRAP_CTRL_MTVAL_EN
        check("mtval_store", mtval, 32'h0000_1003);
        fault_addr = 32'hDEAD_BEE0;
`endif
        check("mtvec_after_redirect_write", trap_handler_addr, 32'h0000_0204);

        // ebreak records its own PC as the trap value
        run_trap(6'b000100, 32'h0000_0040, 1, 32'd3, 6'b0, 1'b0, 1'b0);
`ifdef TRAP_CTRL_MTVAL_EN
        check("mtval_ebreak", mtval, 32'h0000_0040);
`endif

        // Reset while in FLUSH aborts the sequence without a redirect
        drive_flags(6'b001000);
        current_pc = 32'h0000_6000;
        @(negedge CLK);
        drive_flags(6'b0);
        check("pre_rst_flush", 32'(flush_req), 32'd1);
        #2 nRST = 1'b0;
        #1;
        check("midrst_flush_req", 32'(flush_req), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_trap_enable", 32'(trap_enable), 32'd0);
        check("midrst_mret_enable", 32'(mret_enable), 32'd0);
        check("midrst_mtvec", trap_handler_addr, 32'h0000_0100);
        check("midrst_mcause", mcause, 32'd0);
        exp_mtvec = 32'h0000_0100;
        exp_mepc  = 32'h0;
        @(negedge CLK);
        nRST = 1'b1;
        flush_ack = 1'b1;
        repeat (3) @(negedge CLK);
        flush_ack = 1'b0;
        check("post_rst_busy", 32'(busy), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard time limit so a stuck sequence still ends the run
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
